// File: rtl/scope_pkg.sv
// -----------------------------------------------------------------------------
// scope_pkg
// Shared definitions for the scope capture path.
//   - DATA_W_DEF / ADDR_W_DEF : default sample and buffer-address widths, shared
//     with the trigger detector so both blocks agree on the stream format.
//   - state_t                 : capture controller state encoding.
//   - state_is_busy()         : states in which a capture is in progress.
// -----------------------------------------------------------------------------
package scope_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PREFILL   = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   function automatic logic state_is_busy(input state_t s);
      return (s == ST_PREFILL) || (s == ST_WAIT_TRIG) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/capture_ram.sv
// -----------------------------------------------------------------------------
// capture_ram
// Simple dual-port sample buffer: one write port, one read port, registered
// read (1-cycle latency). Written to map onto a block RAM.
//   clk    in   clock for both ports
//   rst    in   synchronous reset of the read-data register only; the array
//               itself is never cleared
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata only updates when re is high, else holds
//   raddr  in   read address
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module capture_ram
   import scope_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_d;
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   // Output register reset maps onto the block RAM's output-latch reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/trig_capture.sv
// -----------------------------------------------------------------------------
// trig_capture
// Capture controller behind the trigger detector. Streams samples into a
// circular buffer, keeps PRE_DEPTH samples of pre-trigger history, records
// POST_LEN = DEPTH - PRE_DEPTH samples starting with the trigger sample, then
// freezes. The frozen buffer is read through a linearised port where logical
// index 0 is the oldest captured sample.
//
// Ports:
//   clk        in   sample clock
//   rst        in   synchronous active-high reset (buffer contents retained)
//   data_in    in   sample stream, aligned with tri_valid
//   tri_valid  in   trigger pulse; data_in of the same cycle is the trigger sample
//   arm        in   start / restart a capture (wins over any trigger that cycle)
//   force_in   in   forced trigger (auto mode)
//   rd_en      in   read request, honoured only once the capture is frozen
//   rd_addr    in   logical read index, 0 = oldest sample
//   rd_data    out  read data, 1 cycle after rd_en; holds between reads
//   rd_valid   out  one-cycle pulse per accepted read
//   done       out  capture complete, buffer frozen
//   busy       out  capture in progress (PREFILL, WAIT_TRIG, POST)
//   dbg_state  out  current controller state (state_t encoding)
//
// Read handshake: a read is accepted on any cycle with rd_en high while the
// controller is in DONE; the matching rd_valid pulse and rd_data appear on the
// following cycle. There is no back-pressure, so reads may issue every cycle.
// -----------------------------------------------------------------------------
module trig_capture
   import scope_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int PRE_DEPTH = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              tri_valid,
   input  logic              arm,
   input  logic              force_in,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              busy,
   output logic [2:0]        dbg_state
);

   localparam int DEPTH    = 1 << ADDR_W;
   localparam int POST_LEN = DEPTH - PRE_DEPTH;

   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_DEPTH);
   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
   localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);

   state_t            state_q,    state_d;
   logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
   logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
   logic [ADDR_W-1:0] pre_cnt_q,  pre_cnt_d;
   logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
   logic              done_q,     done_d;
   logic              busy_q,     busy_d;
   logic              rd_valid_q, rd_valid_d;

   logic              trig_hit;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_raddr;

   assign trig_hit = tri_valid | force_in;

   // Next-state, pointer and counter logic.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      trig_ptr_d = trig_ptr_q;
      pre_cnt_d  = pre_cnt_q;
      post_cnt_d = post_cnt_q;
      ram_we     = 1'b0;

      if (arm) begin
         // Restart from any state; the arm cycle itself writes nothing.
         state_d    = ST_PREFILL;
         wr_ptr_d   = '0;
         trig_ptr_d = '0;
         pre_cnt_d  = '0;
         post_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
            end
            ST_PREFILL: begin
               // Triggers are ignored until the pre-trigger history is full.
               ram_we    = 1'b1;
               wr_ptr_d  = wr_ptr_q + ONE;
               pre_cnt_d = pre_cnt_q + ONE;
               if (pre_cnt_q == PRE_LAST) begin
                  state_d = ST_WAIT_TRIG;
               end
            end
            ST_WAIT_TRIG: begin
               ram_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + ONE;
               if (trig_hit) begin
                  trig_ptr_d = wr_ptr_q;
                  post_cnt_d = ONE;
                  state_d    = (POST_LEN == 1) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               // post_cnt_q counts samples already written, trigger included.
               ram_we     = 1'b1;
               wr_ptr_d   = wr_ptr_q + ONE;
               post_cnt_d = post_cnt_q + ONE;
               if (post_cnt_q == POST_LAST) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Status outputs are registered from the next state so they line up
      // with the state register.
      done_d     = (state_d == ST_DONE);
      busy_d     = state_is_busy(state_d);
      rd_valid_d = rd_en && (state_q == ST_DONE);
   end

   // Oldest captured sample sits PRE_DEPTH slots before the trigger sample;
   // the subtraction wraps naturally in ADDR_W bits.
   assign ram_raddr = trig_ptr_q - PRE_OFS + rd_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         trig_ptr_q <= '0;
         pre_cnt_q  <= '0;
         post_cnt_q <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         trig_ptr_q <= trig_ptr_d;
         pre_cnt_q  <= pre_cnt_d;
         post_cnt_q <= post_cnt_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   capture_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .re    (rd_valid_d),
      .raddr (ram_raddr),
      .rdata (rd_data)
   );

   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_trig_capture.sv
// -----------------------------------------------------------------------------
// tb_trig_capture
// Bench for trig_capture with ADDR_W = 4 (DEPTH = 16), PRE_DEPTH = 4,
// POST_LEN = 12. data_in is driven as (cycles since arm) mod 256, so a capture
// triggered at cycle t must read back t-4 .. t+11 in logical order.
// -----------------------------------------------------------------------------
module tb_trig_capture;
   import scope_pkg::*;

   localparam int AW   = 4;
   localparam int DW   = 8;
   localparam int PRE  = 4;
   localparam int POST = 12;
   localparam int NRD  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          tri_valid = 1'b0;
   logic          arm = 1'b0;
   logic          force_in = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          done;
   logic          busy;
   logic [2:0]    dbg_state;

   int nvec  = 0;
   int nfail = 0;
   int k     = 0;  // cycles since the last arm

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   trig_capture #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .PRE_DEPTH (PRE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .tri_valid (tri_valid),
      .arm       (arm),
      .force_in  (force_in),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .done      (done),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // One clock: inputs set before the call are sampled at this edge; outputs
   // are looked at 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
      k++;
      data_in = DW'(k);
   endtask

   task automatic do_arm();
      arm     = 1'b1;
      k       = 0;
      data_in = '0;
      step();
      arm = 1'b0;
   endtask

   task automatic run_to(input int target);
      while (k < target) step();
   endtask

   task automatic trig_at(input int t, input bit frc);
      run_to(t);
      if (frc) force_in = 1'b1;
      else     tri_valid = 1'b1;
      step();
      tri_valid = 1'b0;
      force_in  = 1'b0;
   endtask

   // done must be low one cycle before exp_k and rise exactly at exp_k.
   task automatic wait_done(input int exp_k);
      int guard;
      run_to(exp_k - 1);
      check("done_early", done, 1'b0);
      guard = 0;
      while (!done && guard < 8) begin
         step();
         guard++;
      end
      check("done_cycle", k, exp_k);
   endtask

   // Read all 16 logical slots back to back in a scrambled order.
   task automatic read_all(input int base);
      logic [AW-1:0] a;
      logic [DW-1:0] last_exp;
      last_exp = '0;
      for (int i = 0; i < NRD; i++) begin
         a       = AW'((i * 5) % NRD);
         rd_en   = 1'b1;
         rd_addr = a;
         step();
         last_exp = DW'(base + int'(a));
         check("rd_valid", rd_valid, 1'b1);
         check("rd_data", rd_data, last_exp);
      end
      rd_en = 1'b0;
      step();
      check("rd_valid_drop", rd_valid, 1'b0);
      check("rd_data_hold", rd_data, last_exp);
   endtask

   // ---------------- directed capture table ----------------
   typedef struct {
      int t_ign;   // trigger issued during PREFILL (ignored), -1 = none
      int t_trig;  // trigger cycle relative to arm
      bit frc;     // use force_in instead of tri_valid
      int base;    // expected value at logical index 0
   } scen_t;

   scen_t scen[5];

   initial begin
      scen[0] = '{t_ign: -1, t_trig: 10, frc: 1'b0, base: 6};
      scen[1] = '{t_ign:  2, t_trig:  8, frc: 1'b0, base: 4};
      scen[2] = '{t_ign: -1, t_trig: 40, frc: 1'b0, base: 36};
      scen[3] = '{t_ign: -1, t_trig: 20, frc: 1'b1, base: 16};
      scen[4] = '{t_ign: -1, t_trig:  5, frc: 1'b0, base: 1};

      // ---- reset with read requests pending ----
      rst     = 1'b1;
      rd_en   = 1'b1;
      rd_addr = 4'd3;
      repeat (3) begin
         step();
         check("rst_rd_valid", rd_valid, 1'b0);
      end
      check("rst_rd_data", rd_data, '0);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_state", dbg_state, ST_IDLE);
      rst = 1'b0;
      step();
      check("idle_rd_valid", rd_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
      rd_en = 1'b0;

      // ---- table-driven captures ----
      for (int s = 0; s < 5; s++) begin
         do_arm();
         check("arm_state", dbg_state, ST_PREFILL);
         check("arm_done", done, 1'b0);
         check("arm_busy", busy, 1'b1);
         rd_en = 1'b1;
         step();
         check("prefill_rd_valid", rd_valid, 1'b0);
         rd_en = 1'b0;
         if (scen[s].t_ign >= 0) trig_at(scen[s].t_ign, 1'b0);
         run_to(PRE + 1);
         check("wait_state", dbg_state, ST_WAIT_TRIG);
         trig_at(scen[s].t_trig, scen[s].frc);
         check("post_state", dbg_state, ST_POST);
         wait_done(scen[s].t_trig + POST);
         check("done_busy", busy, 1'b0);
         check("done_state", dbg_state, ST_DONE);
         read_all(scen[s].base);
         check("done_hold", done, 1'b1);
      end

      // ---- arm + trigger in the same cycle during POST ----
      do_arm();
      trig_at(10, 1'b0);
      run_to(15);
      arm       = 1'b1;
      tri_valid = 1'b1;
      k         = 0;
      data_in   = '0;
      step();
      arm       = 1'b0;
      tri_valid = 1'b0;
      check("abort_state", dbg_state, ST_PREFILL);
      check("abort_done", done, 1'b0);
      check("abort_busy", busy, 1'b1);
      trig_at(10, 1'b0);
      wait_done(10 + POST);
      read_all(6);

      // ---- reset mid-POST, then a fresh capture ----
      do_arm();
      trig_at(6, 1'b0);
      run_to(10);
      check("midpost_state", dbg_state, ST_POST);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstpost_state", dbg_state, ST_IDLE);
      check("rstpost_done", done, 1'b0);
      check("rstpost_busy", busy, 1'b0);
      check("rstpost_rd_data", rd_data, '0);
      check("rstpost_rd_valid", rd_valid, 1'b0);
      repeat (20) step();
      check("rstpost_idle_state", dbg_state, ST_IDLE);
      check("rstpost_idle_done", done, 1'b0);
      do_arm();
      trig_at(12, 1'b0);
      wait_done(12 + POST);
      read_all(8);

      // ---- report ----
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/trig_capture.md
# trig_capture

Capture controller that consumes the trigger detector's output: delayed sample stream plus single-cycle trigger pulse. Writes samples into a circular BRAM, keeps a fixed pre-trigger history, records a fixed post-trigger count, then freezes. The frozen buffer is exposed through a linearised read port (index 0 = oldest sample) for the display/readout path.

## Interface

- ADDR_W, 10, buffer address width; DEPTH = 2^ADDR_W samples
- DATA_W, 8, sample width
- PRE_DEPTH, 512, pre-trigger samples kept; legal range 1..DEPTH-1; POST_LEN = DEPTH-PRE_DEPTH

Ports:

- clk  in  1  sample clock; the only clock
- rst  in  1  synchronous, active-high reset
- data_in  in  DATA_W  sample stream, already aligned to tri_valid
- tri_valid  in  1  trigger pulse; marks data_in of the same cycle as the trigger sample
- arm  in  1  pulse; starts or restarts a capture
- force  in  1  forced trigger (auto mode)
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  logical index, 0 = oldest captured sample
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data valid
- done  out  1  capture complete, buffer frozen
- busy  out  1  high in PREFILL, WAIT_TRIG, POST

## Operation

- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE.
- IDLE: no writes. arm moves to PREFILL.
- PREFILL: write data_in at wr_ptr each cycle; wr_ptr++ mod DEPTH; pre_cnt++. After PRE_DEPTH writes, go to WAIT_TRIG. tri_valid and force are ignored.
- WAIT_TRIG: continuous ring writes.
  - tri_valid | force: that cycle's sample is written, trig_ptr <= wr_ptr, post_cnt <= 1.
  - Next state is POST, or DONE if POST_LEN == 1.
- POST: write each cycle; post_cnt++. After the POST_LEN-th post sample (trigger sample counts as first), go to DONE. Further triggers are ignored.
- DONE: no writes; done = 1. rd_en reads physical address (trig_ptr - PRE_DEPTH + rd_addr) mod DEPTH; all arithmetic is ADDR_W bits, wrapping.
- arm in any state: enter PREFILL, clear counters, deassert done. Memory is not cleared. arm has priority over tri_valid/force in the same cycle.
- rd_en outside DONE: ignored; rd_valid stays 0.
- rst at any time: IDLE, counters 0; memory contents retained.

## Timing

- Reset values: rd_data = 0, rd_valid = 0, done = 0, busy = 0, state = IDLE, wr_ptr = 0.
- Capture start: arm sampled at cycle n; first write is data_in at cycle n+1.
- Trigger to done: trigger sample written at cycle t; last write at t+POST_LEN-1; done = 1 from t+POST_LEN.
- Read latency: 1 cycle. rd_en/rd_addr at cycle k gives rd_data/rd_valid at k+1. rd_valid is a per-request pulse; rd_data holds its value between reads. Back-to-back reads are allowed every cycle.
- done and busy are registered, derived from the state register.

## Structure

- Shared package scope_pkg: state encoding constants; DATA_W/ADDR_W defaults shared with the trigger block.
- Sub-module capture_ram: simple dual-port RAM, one write port and one read port, registered 1-cycle read; infers BRAM.
- trig_capture contains the FSM, pointers, counters and read address translation.

## Test plan

Bench settings: ADDR_W = 4 (DEPTH = 16), PRE_DEPTH = 4, POST_LEN = 12. data_in = (cycles since arm) mod 256.

- Reset: assert rst, pulse rd_en -> all outputs 0, rd_valid never rises, busy = 0.
- Basic capture: arm at t0, tri_valid at t0+10 -> done rises at t0+22. Reading addr 0..15 returns 6..21 with rd_valid one cycle after each rd_en.
- Trigger during prefill: tri_valid at t0+2 (ignored), again at t0+8 -> readback 4..19.
- Ring wrap: tri_valid first at t0+40 -> readback 36..51; done at t0+52.
- Priority/abort: arm and tri_valid in the same cycle during POST -> done stays 0, PREFILL restarts. A later trigger 10 cycles after the new arm reads back 6..21 relative to the new arm.
- Force and reset: force at t0+20 with no tri_valid -> readback 16..31. Separately, rst mid-POST -> state IDLE, done = 0, busy = 0; a following arm and trigger capture correctly.
